// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin 4:1 arbiter with hold limit and registered mux (clk, rst, req[3:0], i0..i3 -> s1/s0, gnt, out, out_valid)
module mux4_arbiter #(
  parameter int W = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic [W-1:0] i2,
  input  logic [W-1:0] i3,
  output logic         s1,
  output logic         s0,
  output logic [3:0]   gnt,
  output logic [W-1:0] out,
  output logic         out_valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, sel, sel_n, pick;
  logic [3:0] hold, hold_n, gnt_n, cand;
  logic found, keep, ov_n;
  logic [W-1:0] d;
  assign {s1, s0} = sel;
  always_comb begin
    cand = (state == GRANT) ? req & ~gnt : req;
    found = 1'b0;
    pick = ptr;
    for (int j = 3; j >= 0; j--) begin
      if (cand[ptr + 2'(j)]) begin
        found = 1'b1;
        pick = ptr + 2'(j);
      end
    end
    keep = state == GRANT && req[sel] && (hold < 4'(MAX_HOLD) || !found);
    state_n = state;
    sel_n = sel;
    gnt_n = gnt;
    ptr_n = ptr;
    hold_n = hold;
    if (keep) hold_n = (hold < 4'(MAX_HOLD)) ? hold + 4'd1 : hold;
    else if (found) begin
      state_n = GRANT;
      sel_n = pick;
      gnt_n = 4'b0001 << pick;
      ptr_n = pick + 2'd1;
      hold_n = 4'd1;
    end else begin
      state_n = IDLE;
      gnt_n = 4'b0000;
    end
    ov_n = state == GRANT && req[sel];
    d = sel[1] ? (sel[0] ? i3 : i2) : (sel[0] ? i1 : i0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= 2'd0;
      gnt <= 4'b0000;
      ptr <= 2'd0;
      hold <= 4'd0;
      out <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      gnt <= gnt_n;
      ptr <= ptr_n;
      hold <= hold_n;
      out_valid <= ov_n;
      if (ov_n) out <= d;
    end
  end
endmodule

// File: tb/tb_mux4_arbiter.sv
// tb_mux4_arbiter: directed checks plus cycle-by-cycle model comparison for mux4_arbiter
module tb_mux4_arbiter;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic [7:0] i0, i1, i2, i3;
  logic s1, s0, out_valid;
  logic [3:0] gnt;
  logic [7:0] out;
  int total = 0;
  int bad = 0;
  mux4_arbiter #(.W(8), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .s1(s1), .s0(s0), .gnt(gnt), .out(out), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  logic [7:0] dv [4];
  int own = -1, mptr = 0, mhold = 0, msel = 0;
  logic [7:0] mout = 8'h00;
  logic mov = 1'b0;
  logic armed = 1'b0;
  logic [3:0] req_at_edge = 4'b0;
  always @(posedge clk) begin
    int nxt;
    req_at_edge = req;
    if (rst) begin
      armed = 1'b1;
      own = -1; mptr = 0; mhold = 0; msel = 0; mout = 8'h00; mov = 1'b0;
    end else begin
      nxt = -1;
      for (int k = 0; k < 4; k++)
        if (nxt < 0 && req[(mptr + k) % 4] && (mptr + k) % 4 != own) nxt = (mptr + k) % 4;
      mov = own >= 0 && req[own];
      if (mov) mout = dv[msel];
      if (own >= 0 && req[own] && (mhold < MH || nxt < 0)) mhold = (mhold < MH) ? mhold + 1 : MH;
      else if (nxt >= 0) begin
        own = nxt; msel = nxt; mptr = (nxt + 1) % 4; mhold = 1;
      end else own = -1;
    end
  end
  logic [3:0] prev_gnt = 4'b0;
  always @(negedge clk) begin
    if (armed) begin
      chk("model_gnt", {4'b0, gnt}, (own < 0) ? 8'h00 : 8'(1 << own));
      chk("model_sel", {6'b0, s1, s0}, 8'(msel));
      chk("model_valid", {7'b0, out_valid}, {7'b0, mov});
      chk("model_out", out, mout);
      chk("onehot", 8'(($countones(gnt) <= 1)), 8'h01);
      if (gnt != 4'b0 && gnt != prev_gnt) chk("gnt_req", {4'b0, gnt & req_at_edge}, {4'b0, gnt});
    end
    prev_gnt = gnt;
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0;
    tick(1);
    rst = 1'b0;
  endtask
  logic [3:0] pats [8] = '{4'b1010, 4'b0101, 4'b1111, 4'b0011, 4'b1000, 4'b0000, 4'b0110, 4'b1101};
  initial begin
    i0 = 8'hA0; i1 = 8'hB1; i2 = 8'hC2; i3 = 8'hD3;
    dv[0] = i0; dv[1] = i1; dv[2] = i2; dv[3] = i3;
    rst = 1'b1;
    req = 4'b0;
    tick(2);
    rst = 1'b0;
    req = 4'b0100;
    tick(1);
    chk("first_gnt", {4'b0, gnt}, 8'h04);
    chk("first_sel", {6'b0, s1, s0}, 8'h02);
    tick(1);
    chk("first_out", out, 8'hC2);
    chk("first_valid", {7'b0, out_valid}, 8'h01);
    req = 4'b0;
    tick(1);
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      chk("rr_gnt", {4'b0, gnt}, 8'(1 << ((c / 4) % 4)));
    end
    do_reset();
    req = 4'b0010;
    tick(2);
    chk("hand_gnt1", {4'b0, gnt}, 8'h02);
    req = 4'b1000;
    tick(1);
    chk("hand_gnt3", {4'b0, gnt}, 8'h08);
    tick(1);
    chk("hand_out", out, 8'hD3);
    chk("hand_valid", {7'b0, out_valid}, 8'h01);
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      chk("single_gnt", {4'b0, gnt}, 8'h01);
    end
    req = 4'b0000;
    tick(1);
    chk("drop_gnt", {4'b0, gnt}, 8'h00);
    chk("drop_sel", {6'b0, s1, s0}, 8'h00);
    chk("drop_valid", {7'b0, out_valid}, 8'h00);
    chk("drop_out", out, 8'hA0);
    do_reset();
    req = 4'b0100;
    tick(2);
    chk("pre_rst_gnt", {4'b0, gnt}, 8'h04);
    rst = 1'b1;
    tick(1);
    chk("rst_gnt", {4'b0, gnt}, 8'h00);
    chk("rst_sel", {6'b0, s1, s0}, 8'h00);
    chk("rst_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_out", out, 8'h00);
    rst = 1'b0;
    req = 4'b0110;
    tick(1);
    chk("post_rst_gnt", {4'b0, gnt}, 8'h02);
    for (int p = 0; p < 8; p++) begin
      req = pats[p];
      tick(3);
    end
    req = 4'b0;
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
